// File: rtl/mux_lut_cell.sv
// mux_lut_cell: run-time programmable K-input logic cell.
//
// A 2^K-entry truth table ("active") is indexed by sel, so any K-input
// Boolean function is chosen by loading a table. Tables arrive serially,
// entry 0 first, into a shadow register. The active table is replaced
// atomically when the last entry is accepted, so the old function stays
// valid for the whole duration of a reload.
//
// Parameters:
//   K       - number of select inputs, legal range 1..6 (table = 2^K bits)
//   REG_OUT - 1: y registered (1-cycle latency), 0: y combinational
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   sel       - function inputs, sel[K-1] is the table index MSB
//   cfg_start - pulse: begin or restart a table load (wins over cfg_valid)
//   cfg_valid - cfg_bit carries a table entry this cycle
//   cfg_bit   - serial table data
//   cfg_ready - high while loading
//   cfg_done  - one-cycle pulse after the new table is committed
//   y         - active[sel]
module mux_lut_cell #(
  parameter int K       = 2,
  parameter bit REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] sel,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         y
);

  localparam int unsigned TBL   = 2 ** K;
  localparam int unsigned CNT_W = K + 1;

  typedef enum logic {
    RUN,
    LOAD
  } state_t;

  state_t           state;
  logic [TBL-1:0]   shadow;
  logic [TBL-1:0]   active;
  logic [TBL-1:0]   shadow_wr;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  // Shadow contents with this cycle's bit merged in; committing this view
  // lets the final entry go straight into active on the same edge.
  always_comb begin
    shadow_wr                 = shadow;
    shadow_wr[cnt[K-1:0]]     = cfg_bit;
  end

  assign last_bit  = (cnt == CNT_W'(TBL - 1));
  assign cfg_ready = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      shadow   <= '0;
      active   <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        RUN: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            cnt <= '0;
          end else if (cfg_valid) begin
            shadow <= shadow_wr;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
              active   <= shadow_wr;
              state    <= RUN;
              cfg_done <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // The table lookup synthesises to the K-level 2:1 mux tree.
  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge clk) begin
        if (rst) begin
          y <= 1'b0;
        end else begin
          y <= active[sel];
        end
      end
    end else begin : g_comb_out
      assign y = active[sel];
    end
  endgenerate

endmodule

// File: tb/tb_mux_lut_cell.sv
module tb_mux_lut_cell;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel2;
  logic       cs, cv, cb;
  logic       ra, da, ya;
  logic       rb, db, yb;
  logic [2:0] sel3;
  logic       cs3, cv3, cb3;
  logic       rc, dc, yc;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_act = 4'b0000;
  logic       sb_q[$];

  always #5 clk = ~clk;

  mux_lut_cell #(.K(2), .REG_OUT(1'b1)) u_a (
    .clk(clk), .rst(rst), .sel(sel2), .cfg_start(cs), .cfg_valid(cv),
    .cfg_bit(cb), .cfg_ready(ra), .cfg_done(da), .y(ya)
  );

  mux_lut_cell #(.K(2), .REG_OUT(1'b0)) u_b (
    .clk(clk), .rst(rst), .sel(sel2), .cfg_start(cs), .cfg_valid(cv),
    .cfg_bit(cb), .cfg_ready(rb), .cfg_done(db), .y(yb)
  );

  mux_lut_cell #(.K(3), .REG_OUT(1'b0)) u_c (
    .clk(clk), .rst(rst), .sel(sel3), .cfg_start(cs3), .cfg_valid(cv3),
    .cfg_bit(cb3), .cfg_ready(rc), .cfg_done(dc), .y(yc)
  );

  // Registered output: expected value pushed when sel is driven, compared
  // after the following edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      logic e;
      e = sb_q.pop_front();
      checks++;
      if (ya !== e) begin
        failures++;
        $display("FAIL sb_y_reg got=%b exp=%b t=%0t", ya, e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // One clock for the K=2 pair: drive, push expectation, advance to just
  // after the next falling edge.
  task automatic cyc(input logic [1:0] s, input logic st, input logic va, input logic bt);
    sel2 = s; cs = st; cv = va; cb = bt;
    sb_q.push_back(rst ? 1'b0 : exp_act[s]);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic load_tbl(input logic [3:0] tbl, input int gap,
                          output int dones, output int rdy_bad, output int comb_bad);
    dones = 0; rdy_bad = 0; comb_bad = 0;
    cyc(sel2, 1'b1, 1'b0, 1'b0);
    if (ra !== 1'b1) rdy_bad++;
    if (yb !== exp_act[sel2]) comb_bad++;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        cyc(sel2, 1'b0, 1'b0, 1'b0);
        if (ra !== 1'b1) rdy_bad++;
        if (yb !== exp_act[sel2]) comb_bad++;
        if (da === 1'b1) dones++;
      end
      cyc(sel2, 1'b0, 1'b1, tbl[i]);
      if (da === 1'b1) dones++;
      if (i == 3) begin
        if (ra !== 1'b0) rdy_bad++;
        if (yb !== tbl[sel2]) comb_bad++;
      end else begin
        if (ra !== 1'b1) rdy_bad++;
        if (yb !== exp_act[sel2]) comb_bad++;
      end
    end
    exp_act = tbl;
    cs = 1'b0; cv = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cs3 = 1'b0; cv3 = 1'b0; cb3 = 1'b0; sel3 = 3'd0;
    cyc(2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cyc(2'(s), 1'b0, 1'b0, 1'b0);
      checks++;
      if (yb !== 1'b0) begin failures++; $display("FAIL reset_y_comb sel=%0d got=%b exp=0", s, yb); end
      checks++;
      if (ra !== 1'b0 || rb !== 1'b0 || rc !== 1'b0) begin
        failures++; $display("FAIL reset_ready got=%b%b%b exp=000", ra, rb, rc);
      end
      checks++;
      if (da !== 1'b0 || db !== 1'b0 || dc !== 1'b0) begin
        failures++; $display("FAIL reset_done got=%b%b%b exp=000", da, db, dc);
      end
    end
    checks++;
    if (yc !== 1'b0) begin failures++; $display("FAIL reset_y_k3 got=%b exp=0", yc); end
  endtask

  task automatic test_and_xor;
    int d, rbad, cbad;
    logic [3:0] t;
    logic [3:0] tables [2] = '{4'b1000, 4'b0110};
    for (int n = 0; n < 2; n++) begin
      t = tables[n];
      load_tbl(t, 0, d, rbad, cbad);
      checks++;
      if (d != 1) begin failures++; $display("FAIL load%0d_done_pulses got=%0d exp=1", n, d); end
      checks++;
      if (rbad != 0) begin failures++; $display("FAIL load%0d_ready got=%0d bad exp=0", n, rbad); end
      checks++;
      if (cbad != 0) begin failures++; $display("FAIL load%0d_comb_y got=%0d bad exp=0", n, cbad); end
      for (int s = 0; s < 4; s++) begin
        cyc(2'(s), 1'b0, 1'b0, 1'b0);
        checks++;
        if (yb !== t[s]) begin failures++; $display("FAIL sweep%0d_y sel=%0d got=%b exp=%b", n, s, yb, t[s]); end
        if (s == 0) begin
          checks++;
          if (da !== 1'b0) begin failures++; $display("FAIL sweep%0d_done_clear got=%b exp=0", n, da); end
        end
      end
    end
  endtask

  task automatic test_stall_shadow;
    int d, rbad, cbad;
    load_tbl(4'b1110, 0, d, rbad, cbad);
    checks++;
    if (d != 1 || cbad != 0) begin failures++; $display("FAIL or_load got=%0d/%0d exp=1/0", d, cbad); end
    sel2 = 2'd0;
    load_tbl(4'b0111, 3, d, rbad, cbad);
    checks++;
    if (d != 1) begin failures++; $display("FAIL nand_done_pulses got=%0d exp=1", d); end
    checks++;
    if (rbad != 0) begin failures++; $display("FAIL nand_ready got=%0d bad exp=0", rbad); end
    checks++;
    if (cbad != 0) begin failures++; $display("FAIL nand_old_fn_comb got=%0d bad exp=0", cbad); end
    checks++;
    if (ya !== 1'b0 || yb !== 1'b1) begin
      failures++; $display("FAIL nand_at_E got=ya%b yb%b exp=ya0 yb1", ya, yb);
    end
    cyc(2'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ya !== 1'b1 || da !== 1'b0) begin
      failures++; $display("FAIL nand_at_E1 got=ya%b done%b exp=ya1 done0", ya, da);
    end
  endtask

  task automatic test_restart;
    int d = 0;
    logic [3:0] t = 4'b0001;
    cyc(2'd0, 1'b1, 1'b0, 1'b0);
    cyc(2'd0, 1'b0, 1'b1, 1'b1);
    cyc(2'd0, 1'b0, 1'b1, 1'b0);
    cyc(2'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ra !== 1'b1 || da !== 1'b0) begin
      failures++; $display("FAIL restart_state got=ready%b done%b exp=ready1 done0", ra, da);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(2'd0, 1'b0, 1'b1, t[i]);
      if (i < 3 && da === 1'b1) d++;
    end
    checks++;
    if (d != 0) begin failures++; $display("FAIL restart_early_done got=%0d exp=0", d); end
    checks++;
    if (da !== 1'b1) begin failures++; $display("FAIL restart_commit_done got=%b exp=1", da); end
    exp_act = t;
    cv = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cyc(2'(s), 1'b0, 1'b0, 1'b0);
      checks++;
      if (yb !== t[s]) begin failures++; $display("FAIL restart_sweep sel=%0d got=%b exp=%b", s, yb, t[s]); end
      if (s == 0) begin
        checks++;
        if (da !== 1'b0) begin failures++; $display("FAIL restart_done_once got=%b exp=0", da); end
      end
    end
  endtask

  task automatic test_reset_midload;
    cyc(2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_act = 4'b0000;
    checks++;
    if (ra !== 1'b0 || yb !== 1'b0 || da !== 1'b0) begin
      failures++; $display("FAIL midrst_state got=ready%b y%b done%b exp=000", ra, yb, da);
    end
    cyc(2'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (da !== 1'b0 || ra !== 1'b0) begin
      failures++; $display("FAIL midrst_no_commit got=done%b ready%b exp=00", da, ra);
    end
    cv = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cyc(2'(s), 1'b0, 1'b0, 1'b0);
      checks++;
      if (yb !== 1'b0) begin failures++; $display("FAIL midrst_sweep sel=%0d got=%b exp=0", s, yb); end
    end
  endtask

  task automatic test_k3_majority;
    logic [7:0] maj = 8'hE8;
    logic [2:0] sv;
    logic       e;
    int d = 0;
    int old_bad = 0;
    sel3 = 3'd7;
    cs3 = 1'b1;
    cyc(sel2, 1'b0, 1'b0, 1'b0);
    cs3 = 1'b0;
    checks++;
    if (rc !== 1'b1) begin failures++; $display("FAIL k3_ready got=%b exp=1", rc); end
    for (int i = 0; i < 8; i++) begin
      cv3 = 1'b1; cb3 = maj[i];
      cyc(sel2, 1'b0, 1'b0, 1'b0);
      if (i < 7) begin
        if (dc === 1'b1) d++;
        if (yc !== 1'b0) old_bad++;
      end
    end
    cv3 = 1'b0;
    checks++;
    if (d != 0 || old_bad != 0) begin
      failures++; $display("FAIL k3_during_load got=done%0d oldbad%0d exp=0/0", d, old_bad);
    end
    checks++;
    if (dc !== 1'b1 || yc !== 1'b1 || rc !== 1'b0) begin
      failures++; $display("FAIL k3_commit got=done%b y%b ready%b exp=110", dc, yc, rc);
    end
    for (int s = 0; s < 8; s++) begin
      sv = 3'(s);
      sel3 = sv;
      e = ($countones(sv) >= 2) ? 1'b1 : 1'b0;
      cyc(sel2, 1'b0, 1'b0, 1'b0);
      checks++;
      if (yc !== e) begin failures++; $display("FAIL k3_maj sel=%0d got=%b exp=%b", s, yc, e); end
    end
    checks++;
    if (dc !== 1'b0) begin failures++; $display("FAIL k3_done_clear got=%b exp=0", dc); end
  endtask

  initial begin
    sel2 = 2'd0; cs = 1'b0; cv = 1'b0; cb = 1'b0;
    test_reset();
    test_and_xor();
    test_stall_shadow();
    test_restart();
    test_reset_midload();
    test_k3_majority();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_lut_cell.md
# mux_lut_cell

Parametrised, run-time programmable logic cell. A 2^K-entry truth table drives a K-level tree of 2:1 multiplexers indexed by `sel`, so any K-input Boolean function (AND, OR, NAND, XOR, majority, …) is selected by loading a table rather than by rewiring gates. The table is loaded serially into a shadow register and committed atomically, so the active function keeps running during a reload. The cell sits in the gate-library area as the generic replacement for fixed mux-built gates.

## Interface
Parameters:
- `K`, default 2: number of select inputs. Legal range is 1..6. The table holds 2^K bits.
- `REG_OUT`, default 1: 1 gives a registered output `y`; 0 gives a combinational `y`.

Ports:
- `clk`, input, width 1: the single clock. All state changes on the rising edge.
- `rst`, input, width 1: reset. Synchronous and active-high.
- `sel`, input, width K: function inputs. `sel[K-1]` is the MSB of the table index.
- `cfg_start`, input, width 1: one-cycle pulse that begins or restarts a table load.
- `cfg_valid`, input, width 1: the config bit on `cfg_bit` is valid this cycle.
- `cfg_bit`, input, width 1: serial table data. Table entry 0 is sent first.
- `cfg_ready`, output, width 1: high while the cell is in LOAD and accepting bits.
- `cfg_done`, output, width 1: one-cycle pulse after the table is committed.
- `y`, output, width 1: equals `active[sel]`.

## Operation
- State is held in these registers: a 2-state FSM (RUN, LOAD), `shadow[2^K-1:0]`, `active[2^K-1:0]`, a bit counter `cnt` of width K+1, `cfg_done`, and `y` when `REG_OUT=1`.
- Reset sets state=RUN, shadow=0, active=0, cnt=0, cfg_done=0 and y=0. After reset the cell outputs constant 0.
- RUN state:
  - `cfg_ready`=0. `cfg_valid` is ignored.
  - `cfg_start`=1 moves the FSM to LOAD and sets cnt=0.
- LOAD state:
  - `cfg_ready`=1.
  - On each cycle with `cfg_valid`=1: `shadow[cnt] <= cfg_bit` and `cnt <= cnt+1`.
  - When the accepted bit has cnt = 2^K-1: `active <=` shadow with bit 2^K-1 replaced by `cfg_bit`, state moves to RUN, and `cfg_done` is set to 1 for exactly one cycle.
  - Cycles with `cfg_valid`=0 are stalls. No timeout applies.
- `cfg_start` has priority over `cfg_valid`.
  - In RUN, a start in the same cycle as a valid bit enters LOAD and drops that bit.
  - In LOAD, a start restarts the load: cnt=0, bits already loaded are discarded, and that cycle's bit is dropped. `active` is unchanged.
- `active` changes only at commit. During a load, `y` keeps evaluating the previous function.
- `shadow` is not cleared on restart. Entries are overwritten in index order, and only a complete load of 2^K bits commits.
- `rst` asserted mid-load aborts the load and forces every reset value, including active=0.
- Selection is a pure index: y = active[sel], using an unsigned index of width K. There is no invalid `sel` value.

## Timing
- `REG_OUT=1`: `y` at edge N+1 reflects `sel` sampled at edge N. Latency is 1 cycle.
- `REG_OUT=0`: `y` follows `sel` combinationally in the same cycle. Latency is 0.
- Let the final config bit be sampled at edge E.
  - `active`, `state`=RUN and `cfg_done`=1 are all visible after E.
  - `cfg_done` returns to 0 after E+1.
  - With `REG_OUT=0` the new function is visible after E.
  - With `REG_OUT=1` the new function is visible after E+1.
- Minimum load time is 2^K accepted cycles plus 1 cycle for `cfg_start`.
- A `cfg_start` in the cycle where `cfg_done`=1 is legal and starts a new load.
- Reset is sampled at the edge like any other input. All outputs are at their reset values after the first edge with `rst`=1.

## Test plan
- **Reset.** Hold `rst`=1 for 2 cycles, then sweep `sel` over 0..3 with K=2 → `y`=0 for every value, `cfg_ready`=0, `cfg_done`=0.
- **AND then XOR, K=2, REG_OUT=1.**
  - Load bits 0,0,0,1 (AND) → `cfg_done` pulses once, then a `sel` sweep over 0..3 gives `y`=0,0,0,1 with 1-cycle latency.
  - Reload with 0,1,1,0 (XOR) → sweep gives 0,1,1,0.
- **Stalls and shadowing.**
  - Load 1,1,1,0 (NAND) over a previously loaded OR table (0,1,1,1), inserting 3 idle cycles between bits → `y` keeps following OR until commit.
  - NAND takes effect exactly at E (`REG_OUT=0`) or at E+1 (`REG_OUT=1`).
- **Restart mid-load.**
  - After 2 bits, pulse `cfg_start` with `cfg_valid`=1 → that bit is dropped and cnt=0.
  - A full 4-bit load afterwards commits only the new 4 bits, and `cfg_done` pulses once.
- **Reset mid-load.** Assert `rst` after 3 of 4 bits → state RUN, `active`=0, `y`=0. A following 1-bit `cfg_valid` produces no commit.
- **K=3 majority, REG_OUT=0.** Load 0,0,0,1,0,1,1,1 (table 0xE8) → `y`=1 exactly for `sel` in {3,5,6,7}. Exhaustive check over all 8 values.
